// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Performs a WIDTH-bit addition over WIDTH/4 cycles by sequencing one external
// 4-bit adder slice. Each cycle one nibble of A and B is presented together with
// the registered carry; the slice result is written into the matching nibble of
// the result register and its carry-out is registered for the next nibble.
//
// Handshake: start is a request that is only sampled in IDLE; the edge that
// samples start=1 captures a/b/c_in. There is no backpressure. busy is high
// during the NIB RUN cycles and done is a single-cycle pulse in the cycle
// after the last nibble edge, while sum/c_out/overflow are valid.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic [1:0]       state_dbg
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             ovf_r;

    // Bit offset of the current nibble and the operand nibbles shifted down to it.
    logic [IDX_W+1:0] nib_pos;
    logic [WIDTH-1:0] op_a_sh;
    logic [WIDTH-1:0] op_b_sh;
    logic [WIDTH-1:0] nib_mask;
    logic [WIDTH-1:0] nib_data;
    logic             last_step;

    assign nib_pos   = {idx, 2'b00};
    assign op_a_sh   = op_a >> nib_pos;
    assign op_b_sh   = op_b >> nib_pos;
    assign nib_mask  = WIDTH'(4'hF) << nib_pos;
    assign nib_data  = WIDTH'(add_sum) << nib_pos;
    assign last_step = (state == RUN) && (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE waits for start, RUN walks NIB nibbles, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: status flags and adder drive; the adder sees zeros outside RUN.
    always_comb begin
        busy    = (state == RUN);
        done    = (state == DONE);
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = op_a_sh[3:0];
            add_b   = op_b_sh[3:0];
            add_cin = carry;
        end
    end

    // Datapath: capture operands on accept, then fold in one nibble result per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= '0;
            carry   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= c_in;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_r <= (sum_r & ~nib_mask) | nib_data;
                    carry <= add_cout;
                    if (last_step) begin
                        // idx returns to 0 so it never leaves 0..NIB-1.
                        idx     <= '0;
                        c_out_r <= add_cout;
                        // add_sum[3] is the MSB of the freshly completed result.
                        ovf_r   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                   (add_sum[3] != op_a[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum       = sum_r;
    assign c_out     = c_out_r;
    assign overflow  = ovf_r;
    assign state_dbg = state;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl (WIDTH=16) with a behavioural 4-bit
// adder slice wired to the add_* ports.
module tb_nibble_serial_adder_ctrl;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
    logic [1:0]   state_dbg;

    // 4-bit adder slice seen by the controller.
    logic [4:0] slice_res;
    assign slice_res = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};
    assign add_sum   = slice_res[3:0];
    assign add_cout  = slice_res[4];

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {overflow, c_out, sum}.
    logic [W+1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of a full-width two's-complement add.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        logic [W:0] r;
        logic       ovf;
        r   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        ovf = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        return {ovf, r[W], r[W-1:0]};
    endfunction

    task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_q.push_back(model(x, y, ci));
    endtask

    task automatic pop_check(input string tag);
        logic [W+1:0] e;
        check({tag, "_q_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_result"}, 32'({overflow, c_out, sum}), 32'(e));
        end
    endtask

    // ---------------- driver / monitor tasks ----------------
    // Waits (bounded) for done, counting busy cycles and recording adder drive.
    task automatic wait_done(output int busy_cycles, output logic [15:0] a_seq,
                             output logic [15:0] b_seq, output logic [3:0] cin_seq,
                             output bit got);
        busy_cycles = 0;
        a_seq = '0;
        b_seq = '0;
        cin_seq = '0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) begin
                if (busy_cycles < 4) begin
                    a_seq[4*busy_cycles +: 4] = add_a;
                    b_seq[4*busy_cycles +: 4] = add_b;
                    cin_seq[busy_cycles]      = add_cin;
                end
                busy_cycles++;
            end
        end
    endtask

    // Checks the done cycle and the return to IDLE after it.
    task automatic check_done_cycle(input string tag, input bit got, input int busy_cycles);
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(busy_cycles), 32'd4);
        pop_check(tag);
        check({tag, "_drive_zero_in_done"}, 32'({add_a, add_b, add_cin}), 32'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'({done, busy}), 32'd0);
    endtask

    // Issues one operation from IDLE (called at a negedge) and checks it to completion.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, output logic [15:0] a_seq, output logic [15:0] b_seq,
                          output logic [3:0] cin_seq);
        int bc;
        bit got;
        a     = x;
        b     = y;
        c_in  = ci;
        start = 1'b1;
        push_exp(x, y, ci);
        @(posedge clk);
        #1 start = 1'b0;
        a    = ~x;
        b    = ~y;
        c_in = ~ci;
        wait_done(bc, a_seq, b_seq, cin_seq, got);
        check_done_cycle(tag, got, bc);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] as;
        logic [15:0] bs;
        logic [3:0]  cs;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         rc;
        int bc;
        bit got;
        bit any_done;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_flags", 32'({busy, done, c_out, overflow}), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_adder_drive", 32'({add_a, add_b, add_cin}), 32'd0);

        // Plain add, also checks nibble ordering on add_a/add_b.
        run_op("add_1234_1111", 16'h1234, 16'h1111, 1'b0, as, bs, cs);
        check("add_1234_nibbles_a", 32'(as), 32'h1234);
        check("add_1234_nibbles_b", 32'(bs), 32'h1111);
        check("add_1234_cin_seq", 32'(cs), 32'h0);

        // Carry ripples across every nibble boundary.
        run_op("ripple_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, as, bs, cs);
        check("ripple_cin_seq", 32'(cs), 32'b1110);
        check("ripple_sum_const", 32'({c_out, sum}), 32'h10000);

        // Signed overflow.
        run_op("ovf_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, as, bs, cs);
        check("ovf_flag_const", 32'(overflow), 32'd1);

        // Initial carry-in, then a carry-free add right after.
        run_op("cin_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, as, bs, cs);
        check("cin_first_cin", 32'(cs[0]), 32'd1);
        run_op("add_0aaa_0555", 16'h0AAA, 16'h0555, 1'b0, as, bs, cs);
        check("add_0aaa_const", 32'({c_out, sum}), 32'h0FFF);

        // Held start: operands changed during RUN must not affect the first op;
        // the second op is accepted once back in IDLE.
        a     = 16'h0001;
        b     = 16'h0001;
        c_in  = 1'b0;
        start = 1'b1;
        push_exp(16'h0001, 16'h0001, 1'b0);
        @(posedge clk);
        #1 a = 16'hF000;
        b = 16'hF000;
        push_exp(16'hF000, 16'hF000, 1'b0);
        wait_done(bc, as, bs, cs, got);
        check("held_first_done", 32'(got), 32'd1);
        pop_check("held_first");
        check("held_first_const", 32'(sum), 32'h0002);
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(bc, as, bs, cs, got);
        check_done_cycle("held_second", got, bc);
        check("held_second_const", 32'({c_out, sum}), 32'h1E000);

        // Reset while idx=2: everything cleared, no done for the aborted op.
        a     = 16'h1234;
        b     = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_busy_done", 32'({busy, done}), 32'd0);
        check("midreset_sum", 32'(sum), 32'd0);
        check("midreset_cout_ovf", 32'({c_out, overflow}), 32'd0);
        any_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) any_done = 1'b1;
        end
        check("midreset_no_done", 32'(any_done), 32'd0);
        run_op("after_reset_0010_0020", 16'h0010, 16'h0020, 1'b0, as, bs, cs);
        check("after_reset_const", 32'(sum), 32'h0030);

        // A few random operands against the model.
        for (int i = 0; i < 6; i++) begin
            rx = W'($urandom_range(0, 16'hFFFF));
            ry = W'($urandom_range(0, 16'hFFFF));
            rc = 1'($urandom_range(0, 1));
            run_op("random_op", rx, ry, rc, as, bs, cs);
            check("random_nibbles_a", 32'(as), 32'(rx));
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
